// File: rtl/mcpu_instr_decoder.sv
// MCPU decode stage: splits 16-bit words into fields and strobes behind a skid buffer.
// Optional MCPU_DECODE_STATS_EN adds stat_decoded/stat_illegal counters.
module mcpu_instr_decoder #(
  parameter int WORD_SIZE = 16,
  parameter int OPCODE_SIZE = 4,
  parameter int OPERAND_SIZE = 4,
  parameter logic [OPCODE_SIZE-1:0] OP_MOV = 4'd0,
  parameter logic [OPCODE_SIZE-1:0] OP_ADD = 4'd1,
  parameter logic [OPCODE_SIZE-1:0] OP_XOR = 4'd2,
  parameter logic [OPCODE_SIZE-1:0] OP_SHORT_TO_REG = 4'd3,
  parameter logic [OPCODE_SIZE-1:0] OP_LOAD_FROM_MEM = 4'd4,
  parameter logic [OPCODE_SIZE-1:0] OP_STORE_TO_MEM = 4'd5
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  output logic out_valid,
  input  logic out_ready,
  output logic [2:0] out_kind,
  output logic [OPERAND_SIZE-1:0] out_rd,
  output logic [OPERAND_SIZE-1:0] out_ra,
  output logic [OPERAND_SIZE-1:0] out_rb,
  output logic [7:0] out_imm,
  output logic out_reg_we,
  output logic out_mem_we,
  output logic out_mem_re
`ifdef MCPU_DECODE_STATS_EN
  ,
  output logic [15:0] stat_decoded,
  output logic [15:0] stat_illegal
`endif
);

  typedef struct packed {
    logic [2:0] kind;
    logic [OPERAND_SIZE-1:0] rd;
    logic [OPERAND_SIZE-1:0] ra;
    logic [OPERAND_SIZE-1:0] rb;
    logic [7:0] imm;
    logic reg_we;
    logic mem_we;
    logic mem_re;
  } dec_t;

  dec_t m, s, d;
  logic m_valid, s_valid;
  logic xfer_in, m_free;
  logic [OPCODE_SIZE-1:0] op;

  assign op = in_instr[WORD_SIZE-1 -: OPCODE_SIZE];

  always_comb begin
    d = '0;
    d.rd = in_instr[2*OPERAND_SIZE +: OPERAND_SIZE];
    d.ra = in_instr[OPERAND_SIZE +: OPERAND_SIZE];
    d.rb = in_instr[0 +: OPERAND_SIZE];
    d.imm = in_instr[7:0];
    unique case (1'b1)
      (op == OP_MOV): begin
        d.kind = 3'd0;
        d.reg_we = 1'b1;
      end
      (op == OP_ADD): begin
        d.kind = 3'd1;
        d.reg_we = 1'b1;
      end
      (op == OP_XOR): begin
        d.kind = 3'd2;
        d.reg_we = 1'b1;
      end
      (op == OP_SHORT_TO_REG): begin
        d.kind = 3'd3;
        d.reg_we = 1'b1;
      end
      (op == OP_LOAD_FROM_MEM): begin
        d.kind = 3'd4;
        d.reg_we = 1'b1;
        d.mem_re = 1'b1;
      end
      (op == OP_STORE_TO_MEM): begin
        d.kind = 3'd5;
        d.mem_we = 1'b1;
      end
      default: d.kind = 3'd7;
    endcase
  end

  // in_ready comes straight from a flop, never from out_ready
  assign in_ready = ~s_valid;
  assign xfer_in = in_valid & ~s_valid;
  assign m_free = ~m_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '0;
      s <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m <= s;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (xfer_in) begin
        m <= d;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (xfer_in) begin
      s <= d;
      s_valid <= 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_kind = m.kind;
  assign out_rd = m.rd;
  assign out_ra = m.ra;
  assign out_rb = m.rb;
  assign out_imm = m.imm;
  assign out_reg_we = m.reg_we;
  assign out_mem_we = m.mem_we;
  assign out_mem_re = m.mem_re;

`ifdef MCPU_DECODE_STATS_EN
  logic xfer_out;
  assign xfer_out = m_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (xfer_out) begin
      stat_decoded <= stat_decoded + 16'd1;
      if (m.kind == 3'd7)
        stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcpu_instr_decoder.sv
// Directed bench for mcpu_instr_decoder.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_mcpu_instr_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_instr = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [2:0] out_kind;
  logic [3:0] out_rd, out_ra, out_rb;
  logic [7:0] out_imm;
  logic out_reg_we, out_mem_we, out_mem_re;
`ifdef MCPU_DECODE_STATS_EN
  logic [15:0] stat_decoded, stat_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_instr_decoder dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_kind(out_kind),
    .out_rd(out_rd),
    .out_ra(out_ra),
    .out_rb(out_rb),
    .out_imm(out_imm),
    .out_reg_we(out_reg_we),
    .out_mem_we(out_mem_we),
    .out_mem_re(out_mem_re)
`ifdef MCPU_DECODE_STATS_EN
    ,
    .stat_decoded(stat_decoded),
    .stat_illegal(stat_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind, rd, ra, rb, imm, reg_we, mem_we, mem_re in one go
  task automatic check_out(input string tag, input logic [2:0] k,
                           input logic [3:0] rd, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [7:0] imm,
                           input logic [2:0] strb);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".kind"}, {29'd0, out_kind}, {29'd0, k});
    check({tag, ".rd"}, {28'd0, out_rd}, {28'd0, rd});
    check({tag, ".ra"}, {28'd0, out_ra}, {28'd0, ra});
    check({tag, ".rb"}, {28'd0, out_rb}, {28'd0, rb});
    check({tag, ".imm"}, {24'd0, out_imm}, {24'd0, imm});
    check({tag, ".strb"}, {29'd0, out_reg_we, out_mem_we, out_mem_re},
          {29'd0, strb});
  endtask

  initial begin
    // reset state
    #12;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    check("rst.kind", {29'd0, out_kind}, 32'd0);
    check("rst.fields", {out_rd, out_ra, out_rb, out_imm}, 32'd0);
    check("rst.strb", {29'd0, out_reg_we, out_mem_we, out_mem_re}, 32'd0);
    tick();
    reset = 1'b0;

    // 1: ADD R2,R0,R1
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h1201;
    tick();
    check_out("add", 3'd1, 4'd2, 4'd0, 4'd1, 8'h01, 3'b100);

    // 2: back-to-back stream
    in_instr = 16'h3014;
    tick();
    check_out("s2r", 3'd3, 4'd0, 4'd1, 4'd4, 8'h14, 3'b100);
    check("s2r.rdy", {31'd0, in_ready}, 32'd1);
    in_instr = 16'h5214;
    tick();
    check_out("st", 3'd5, 4'd2, 4'd1, 4'd4, 8'h14, 3'b010);
    check("st.rdy", {31'd0, in_ready}, 32'd1);
    in_instr = 16'h4314;
    tick();
    check_out("ld", 3'd4, 4'd3, 4'd1, 4'd4, 8'h14, 3'b101);
    check("ld.rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain.valid", {31'd0, out_valid}, 32'd0);
    check("hold.kind", {29'd0, out_kind}, 32'd4);

    // 3: backpressure fills M then S
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 16'h0F60;
    tick();
    check_out("mov.m", 3'd0, 4'd15, 4'd6, 4'd0, 8'h60, 3'b100);
    check("mov.rdy", {31'd0, in_ready}, 32'd1);
    in_instr = 16'h2BA1;
    tick();
    check_out("mov.hold", 3'd0, 4'd15, 4'd6, 4'd0, 8'h60, 3'b100);
    check("skid.rdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tick();
    check_out("mov.stall", 3'd0, 4'd15, 4'd6, 4'd0, 8'h60, 3'b100);
    out_ready = 1'b1;
    tick();
    check_out("xor", 3'd2, 4'd11, 4'd10, 4'd1, 8'hA1, 3'b100);
    check("xor.rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("xor.done", {31'd0, out_valid}, 32'd0);

    // 4: illegal opcode
    in_valid = 1'b1;
    in_instr = 16'hF123;
    tick();
    check_out("ill", 3'd7, 4'd1, 4'd2, 4'd3, 8'h23, 3'b000);
    in_valid = 1'b0;
    tick();
    check("ill.done", {31'd0, out_valid}, 32'd0);
`ifdef MCPU_DECODE_STATS_EN
    check("stat.dec", {16'd0, stat_decoded}, 32'd7);
    check("stat.ill", {16'd0, stat_illegal}, 32'd1);
`endif

    // 5: async reset with M and S full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 16'h1111;
    tick();
    in_instr = 16'h2222;
    tick();
    check("full.rdy", {31'd0, in_ready}, 32'd0);
    check("full.valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar.valid", {31'd0, out_valid}, 32'd0);
    check("ar.rdy", {31'd0, in_ready}, 32'd1);
    check("ar.kind", {29'd0, out_kind}, 32'd0);
    check("ar.rd", {28'd0, out_rd}, 32'd0);
    in_instr = 16'h3333;
    tick();
    check("ign.valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post.valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("post.valid2", {31'd0, out_valid}, 32'd0);
    check("post.rdy", {31'd0, in_ready}, 32'd1);

`ifdef MCPU_DECODE_STATS_EN
    check("post.sdec", {16'd0, stat_decoded}, 32'd0);
    check("post.sill", {16'd0, stat_illegal}, 32'd0);
    // 6: 65537 transfers out wraps the counter to 1
    in_valid = 1'b1;
    in_instr = 16'hF000;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick();
    check("wrap.dec", {16'd0, stat_decoded}, 32'd1);
    check("wrap.ill", {16'd0, stat_illegal}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
